// File: rtl/truth_table_checker_if.sv
// Handshake bundle carrying (input vector, circuit response) pairs to the checker.
//   vec_valid : source holds a pair on vec_in/resp_in
//   vec_ready : checker accepts a pair this cycle
//   vec_in    : input vector applied to the circuit under test
//   resp_in   : circuit response to vec_in
// master drives the pairs; slave is the checker side.
interface truth_table_checker_if #(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned OUT_W = 5
);
    logic             vec_valid;
    logic             vec_ready;
    logic [IN_W-1:0]  vec_in;
    logic [OUT_W-1:0] resp_in;

    modport master (
        output vec_valid,
        output vec_in,
        output resp_in,
        input  vec_ready
    );

    modport slave (
        input  vec_valid,
        input  vec_in,
        input  resp_in,
        output vec_ready
    );
endinterface

// File: rtl/truth_table_checker.sv
// Checks a stream of (vector, response) pairs against a parameterised truth table.
// Counts mismatching responses, captures the first failing pair, flags vectors that
// arrive out of ascending order, and reports pass/fail after all 2**IN_W vectors.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   start            : one-cycle pulse that begins/restarts a run (ignored while running)
//   bus (slave)      : vec_valid/vec_ready handshake with vec_in/resp_in
//   busy             : run in progress
//   done             : run complete, results stable until next start or reset
//   pass             : done with no mismatch and no order error
//   err_count        : mismatching pairs this run
//   order_err        : sticky, some vec_in differed from its expected position
//   first_fail_vec   : vec_in of the first mismatch (0 if none)
//   first_fail_resp  : resp_in of the first mismatch (0 if none)
module truth_table_checker #(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned OUT_W = 5,
    parameter logic [(2**IN_W)*OUT_W-1:0] EXP_TABLE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    truth_table_checker_if.slave  bus,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [IN_W:0]         err_count,
    output logic                  order_err,
    output logic [IN_W-1:0]       first_fail_vec,
    output logic [OUT_W-1:0]      first_fail_resp
);

    localparam int unsigned NumVec = 2**IN_W;
    localparam logic [IN_W:0] LastIdx = (IN_W+1)'(NumVec - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e state_q, state_d;

    logic [IN_W:0]      idx_q;
    logic [IN_W:0]      err_q;
    logic               order_q;
    logic [IN_W-1:0]    ffv_q;
    logic [OUT_W-1:0]   ffr_q;

    logic               accept;
    logic               last_accept;
    logic               run_entry;
    logic               mismatch;
    logic               out_of_order;

    // Unpack the flat table so the lookup is a plain array index by vec_in.
    logic [OUT_W-1:0] exp_mem [NumVec];
    for (genvar k = 0; k < NumVec; k++) begin : g_exp
        assign exp_mem[k] = EXP_TABLE[k*OUT_W +: OUT_W];
    end

    always_comb begin
        accept       = bus.vec_valid && (state_q == StRun);
        last_accept  = accept && (idx_q == LastIdx);
        run_entry    = start && (state_q != StRun);
        // Lookup keyed by the received vector, not the position counter.
        mismatch     = bus.resp_in != exp_mem[bus.vec_in];
        out_of_order = {1'b0, bus.vec_in} != idx_q;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start)       state_d = StRun;
            StRun:   if (last_accept) state_d = StDone;
            StDone:  if (start)       state_d = StRun;
            default:                  state_d = StIdle;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        bus.vec_ready = (state_q == StRun);
        busy          = (state_q == StRun);
        done          = (state_q == StDone);
        pass          = done && (err_q == '0) && !order_q;
    end

    // Run datapath: cleared on entry to a run, updated per accepted pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            err_q   <= '0;
            order_q <= 1'b0;
            ffv_q   <= '0;
            ffr_q   <= '0;
        end else if (run_entry) begin
            idx_q   <= '0;
            err_q   <= '0;
            order_q <= 1'b0;
            ffv_q   <= '0;
            ffr_q   <= '0;
        end else if (accept) begin
            idx_q <= idx_q + 1'b1;
            if (mismatch) begin
                err_q <= err_q + 1'b1;
                if (err_q == '0) begin
                    ffv_q <= bus.vec_in;
                    ffr_q <= bus.resp_in;
                end
            end
            if (out_of_order) begin
                order_q <= 1'b1;
            end
        end
    end

    assign err_count       = err_q;
    assign order_err       = order_q;
    assign first_fail_vec  = ffv_q;
    assign first_fail_resp = ffr_q;

endmodule

// File: tb/tb_truth_table_checker.sv
module tb_truth_table_checker;

    // Reference truth table: an arbitrary 4-in/5-out function.
    function automatic logic [4:0] ref_resp(input int k);
        return 5'((k * 11 + 7) % 32);
    endfunction

    function automatic logic [79:0] build_table();
        logic [79:0] t;
        t = '0;
        for (int k = 0; k < 16; k++) t[k*5 +: 5] = ref_resp(k);
        return t;
    endfunction

    localparam logic [79:0] EXP = build_table();

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       busy, done, pass;
    logic [4:0] err_count;
    logic       order_err;
    logic [3:0] first_fail_vec;
    logic [4:0] first_fail_resp;

    always #5 clk = ~clk;

    truth_table_checker_if #(.IN_W(4), .OUT_W(5)) bus_if ();

    truth_table_checker #(.IN_W(4), .OUT_W(5), .EXP_TABLE(EXP)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .bus             (bus_if),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .order_err       (order_err),
        .first_fail_vec  (first_fail_vec),
        .first_fail_resp (first_fail_resp)
    );

    int total = 0;
    int bad   = 0;

    logic [3:0] v_arr [16];
    logic [4:0] r_arr [16];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_clean();
        for (int i = 0; i < 16; i++) begin
            v_arr[i] = 4'(i);
            r_arr[i] = ref_resp(i);
        end
    endtask

    // Expected run results straight from the list of pairs sent.
    task automatic model(output int e_err, output int e_fv, output int e_fr, output bit e_ord);
        e_err = 0; e_fv = 0; e_fr = 0; e_ord = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (r_arr[i] != ref_resp(int'(v_arr[i]))) begin
                if (e_err == 0) begin
                    e_fv = int'(v_arr[i]);
                    e_fr = int'(r_arr[i]);
                end
                e_err++;
            end
            if (int'(v_arr[i]) != i) e_ord = 1'b1;
        end
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle before each pair, 2 random 0..2 idle cycles.
    // start_at: pair index during which start is also pulsed (out of range = never).
    task automatic run_pairs(input bit do_start, input int gap_mode, input int start_at,
                             input int count);
        int gaps;
        if (do_start) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        check_eq("busy_in_run", busy, 1);
        for (int i = 0; i < count; i++) begin
            gaps = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(2, 0));
            repeat (gaps) begin
                bus_if.vec_valid = 1'b0;
                @(posedge clk); #1;
            end
            check_eq("no_early_done", done, 0);
            check_eq("ready_in_run", bus_if.vec_ready, 1);
            bus_if.vec_valid = 1'b1;
            bus_if.vec_in    = v_arr[i];
            bus_if.resp_in   = r_arr[i];
            start            = (i == start_at);
            @(posedge clk); #1;
            start = 1'b0;
        end
        bus_if.vec_valid = 1'b0;
    endtask

    task automatic check_results(input string tag);
        int e_err, e_fv, e_fr;
        bit e_ord;
        model(e_err, e_fv, e_fr, e_ord);
        check_eq({tag, "_done"}, done, 1);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_ready"}, bus_if.vec_ready, 0);
        check_eq({tag, "_err"}, err_count, e_err);
        check_eq({tag, "_order"}, order_err, e_ord);
        check_eq({tag, "_ffv"}, first_fail_vec, e_fv);
        check_eq({tag, "_ffr"}, first_fail_resp, e_fr);
        check_eq({tag, "_pass"}, pass, (e_err == 0 && !e_ord) ? 1 : 0);
    endtask

    // Drive wrong pairs while not running; nothing may be consumed.
    task automatic junk_while_idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            bus_if.vec_valid = 1'b1;
            bus_if.vec_in    = 4'($urandom_range(15, 0));
            bus_if.resp_in   = ~ref_resp(int'(bus_if.vec_in));
            @(posedge clk); #1;
        end
        bus_if.vec_valid = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_pass"}, pass, 0);
        check_eq({tag, "_err"}, err_count, 0);
        check_eq({tag, "_order"}, order_err, 0);
        check_eq({tag, "_ffv"}, first_fail_vec, 0);
        check_eq({tag, "_ffr"}, first_fail_resp, 0);
        check_eq({tag, "_ready"}, bus_if.vec_ready, 0);
    endtask

    initial begin
        logic [3:0] tv;
        logic [4:0] tr;
        int j;

        rst_n = 1'b0;
        start = 1'b0;
        bus_if.vec_valid = 1'b0;
        bus_if.vec_in    = '0;
        bus_if.resp_in   = '0;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        junk_while_idle(3);
        check_zero("idle_ignore");

        // Clean ordered run
        fill_clean();
        run_pairs(1'b1, 0, -1, 16);
        check_results("clean");
        junk_while_idle(3);
        check_results("done_ignore");

        // Two corrupted responses
        fill_clean();
        r_arr[5] ^= 5'd1;
        r_arr[9] ^= 5'd1;
        run_pairs(1'b1, 0, -1, 16);
        check_results("flip59");

        // Restart from DONE clears results
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("restart_done", done, 0);
        check_eq("restart_err", err_count, 0);
        check_eq("restart_ffv", first_fail_vec, 0);
        check_eq("restart_ffr", first_fail_resp, 0);
        check_eq("restart_busy", busy, 1);
        fill_clean();
        run_pairs(1'b0, 0, -1, 16);
        check_results("after_restart");

        // Vectors 3 and 4 swapped, responses correct
        fill_clean();
        v_arr[3] = 4'd4; r_arr[3] = ref_resp(4);
        v_arr[4] = 4'd3; r_arr[4] = ref_resp(3);
        run_pairs(1'b1, 0, -1, 16);
        check_results("swap34");

        // Toggled valid with start pulsed mid-run
        fill_clean();
        r_arr[12] ^= 5'd4;
        run_pairs(1'b1, 1, 8, 16);
        check_results("toggle_start");

        // Start coincident with the final acceptance
        fill_clean();
        run_pairs(1'b1, 0, 15, 16);
        check_results("start_at_last");

        // Reset mid-run after 7 accepts
        fill_clean();
        r_arr[2] ^= 5'd1;
        run_pairs(1'b1, 0, -1, 7);
        check_eq("partial_err", err_count, 1);
        rst_n = 1'b0;
        #1;
        check_zero("midrun_reset");
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        fill_clean();
        run_pairs(1'b1, 0, -1, 16);
        check_results("post_reset");

        // Randomised runs
        for (int n = 0; n < 30; n++) begin
            fill_clean();
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(5, 0) == 0) r_arr[i] ^= 5'($urandom_range(31, 1));
            end
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(4, 0) == 0) begin
                    j = int'($urandom_range(15, 0));
                    tv = v_arr[i]; tr = r_arr[i];
                    v_arr[i] = v_arr[j]; r_arr[i] = r_arr[j];
                    v_arr[j] = tv; r_arr[j] = tr;
                end
            end
            run_pairs(1'b1, 2, int'($urandom_range(24, 0)), 16);
            check_results("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
